// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-control stage: FSM state encoding,
// default timing parameters and a counter-width helper.
package clkctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STEP_HI   = 2'd1,
    STEP_WAIT = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_RUN_DIV         = 25_000_000;
  localparam int DEF_SCAN_DIV        = 50_000;

  // Width of a counter that must hold 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Board-side signal bundle of the clock-control stage.
// All signals are plain levels; there is no valid/ready handshake. The board
// (master) drives the raw button and switch; the controller (slave) drives
// the generated clocks, the run indicator, the cycle count and its FSM state.
interface cpu_clk_ctrl_if;
  import clkctrl_pkg::*;

  logic        btn_step;
  logic        sw_run;
  logic        tclk;
  logic        dclk;
  logic        running;
  logic [31:0] cycle_cnt;
  state_e      dbg_state;

  modport master (
    output btn_step, sw_run,
    input  tclk, dclk, running, cycle_cnt, dbg_state
  );

  modport slave (
    input  btn_step, sw_run,
    output tclk, dclk, running, cycle_cnt, dbg_state
  );

endinterface

// File: rtl/cpu_clk_ctrl_debounce.sv
// Two-flop synchronizer followed by a stable-count filter. The output level
// only changes once the synchronized input has disagreed with it for CYCLES
// consecutive clock cycles; any agreement in between restarts the count.
module debounce
  import clkctrl_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int           W    = cnt_w(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic         sync1_q, sync2_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         dout_q, dout_d;

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (sync2_q != dout_q) begin
      if (cnt_q == LAST) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and filter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-control stage: produces single-step pulses or a divided
// free-running CPU clock (tclk), a free-running display scan clock (dclk)
// and a count of tclk rising edges.
// Optional feature macro: CLKCTRL_CYCLE_CNT_EN enables the cycle counter;
// without it cycle_cnt is a constant zero.
module cpu_clk_ctrl
  import clkctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int SCAN_DIV        = DEF_SCAN_DIV
) (
  input  logic           clk,
  input  logic           reset,
  cpu_clk_ctrl_if.slave  io
);

  localparam int            RW        = cnt_w(RUN_DIV);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_DIV - 1);
  localparam int            SW        = cnt_w(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic btn_db, sw_db;
  logic btn_prev_q;
  logic step_req;

  state_e        state_q, state_d;
  logic          tclk_q, tclk_d;
  logic          running_q, running_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          dclk_q, dclk_d;

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk   (clk),
    .rst_n (reset),
    .din   (io.btn_step),
    .dout  (btn_db)
  );

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk   (clk),
    .rst_n (reset),
    .din   (io.sw_run),
    .dout  (sw_db)
  );

  // Previous debounced button level, for the one-cycle step request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_db;
    end
  end

  assign step_req = btn_db & ~btn_prev_q;

  // Next-state and tclk logic; a run-mode stop never cuts a high phase short.
  always_comb begin
    state_d   = state_q;
    tclk_d    = tclk_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      IDLE: begin
        tclk_d    = 1'b0;
        run_cnt_d = '0;
        if (sw_db) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d = STEP_HI;
          tclk_d  = 1'b1;
        end
      end
      STEP_HI: begin
        if (run_cnt_q == RUN_LAST) begin
          tclk_d    = 1'b0;
          run_cnt_d = '0;
          state_d   = STEP_WAIT;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      STEP_WAIT: begin
        tclk_d = 1'b0;
        if (!btn_db) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!sw_db && !tclk_q) begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end else if (run_cnt_q == RUN_LAST) begin
          run_cnt_d = '0;
          tclk_d    = ~tclk_q;
          if (!sw_db) begin
            state_d = IDLE;
          end
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tclk_d    = 1'b0;
        run_cnt_d = '0;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tclk_q    <= 1'b0;
      running_q <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tclk_q    <= tclk_d;
      running_q <= running_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Display scan divider, free-running in every FSM state.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dclk_d     = dclk_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      dclk_d     = ~dclk_q;
    end
  end

  // Scan divider state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      dclk_q     <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dclk_q     <= dclk_d;
    end
  end

`ifdef CLKCTRL_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Count tclk rises on the same edge that raises tclk; wraps naturally.
  always_comb begin
    cyc_d = cyc_q;
    if (tclk_d && !tclk_q) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Cycle counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign io.cycle_cnt = cyc_q;
`else
  assign io.cycle_cnt = 32'h0;
`endif

  assign io.tclk      = tclk_q;
  assign io.dclk      = dclk_q;
  assign io.running   = running_q;
  assign io.dbg_state = state_q;

endmodule
